// File: rtl/xor_arbiter_pkg.sv
// Shared types and helpers for the XOR arbiter: result-register state and
// the width of a requester index.
package xor_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Never narrower than one bit, so a two-requester build still has an index.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xor_arbiter_rr_pick.sv
// Round-robin priority search: one-hot grant to the first valid requester
// at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/xor_arbiter.sv
// N requesters share one W-bit XOR unit; a single-entry result register
// drains to a ready/valid consumer, refilling in the same cycle it drains.
module xor_arbiter
  import xor_arbiter_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                req_valid,
  input  logic [N*W-1:0]              req_a,
  input  logic [N*W-1:0]              req_b,
  output logic [N-1:0]                req_ready,
  output logic                        res_valid,
  output logic [W-1:0]                res_data,
  output logic [idx_width(N)-1:0]     res_id,
  input  logic                        res_ready
);

  localparam int IW = idx_width(N);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] id_q, id_d;

  logic [N-1:0]  grant;
  logic [IW-1:0] gIdx;
  logic          canAccept;
  logic          xfer;
  logic [W-1:0]  opA, opB, xorRes;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gIdx)
  );

  // A draining FULL register can take a new result in the same cycle.
  assign canAccept = !rst && ((state_q == EMPTY) || res_ready);
  assign req_ready = canAccept ? grant : '0;
  assign xfer      = canAccept && (|req_valid);

  assign opA    = req_a[int'(gIdx)*W +: W];
  assign opB    = req_b[int'(gIdx)*W +: W];
  assign xorRes = opA ^ opB;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = xorRes;
      id_d    = gIdx;
      ptr_d   = (gIdx == IW'(N - 1)) ? '0 : gIdx + IW'(1);
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = data_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_xor_arbiter.sv
// Self-checking bench for xor_arbiter: directed scenarios followed by
// randomized traffic, all scored against a behavioural model.
module tb_xor_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic [W-1:0]    res_data;
  logic [IW-1:0]   res_id;
  logic            res_ready;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Behavioural model of the visible result register and round-robin pointer.
  bit            mFull = 1'b0;
  logic [W-1:0]  mData = '0;
  int            mId   = 0;
  int            mPtr  = 0;

  xor_arbiter #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requester with a request, scanning upward from p and wrapping.
  function automatic int pickRef(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Drives one cycle, checks every output against the model (and against a
  // hard-coded grant when expGrant >= -1), then advances the model.
  // Returns before the rising edge, so outputs still show this cycle.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v,
                               input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                               input logic rdy, input int expGrant);
    int g;
    logic [N-1:0] expReady;
    @(negedge clk);
    rst = r; req_valid = v; req_a = a; req_b = b; res_ready = rdy;
    #1;
    g = (!r && (!mFull || rdy)) ? pickRef(v, mPtr) : -1;
    expReady = (g >= 0) ? N'(1 << g) : '0;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("res_valid", 32'(res_valid), 32'(mFull));
    checkOutput("res_data",  32'(res_data),  32'(mData));
    checkOutput("res_id",    32'(res_id),    32'(mId));
    if (expGrant >= 0)       checkOutput("grant_seq", 32'(req_ready), 32'(1) << expGrant);
    else if (expGrant == -1) checkOutput("no_grant",  32'(req_ready), 32'(0));
    if (r) begin
      mFull = 1'b0; mData = '0; mId = 0; mPtr = 0;
    end else if (g >= 0) begin
      mFull = 1'b1;
      mData = a[g*W +: W] ^ b[g*W +: W];
      mId   = g;
      mPtr  = (g + 1) % N;
    end else if (mFull && rdy) begin
      mFull = 1'b0;
    end
  endtask

  function automatic logic [N*W-1:0] randOps();
    logic [N*W-1:0] x;
    for (int i = 0; i < N; i++) x[i*W +: W] = W'($urandom);
    return x;
  endfunction

  initial begin
    logic [N*W-1:0] a, b;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;

    // Reset with every requester asking: nothing granted, register cleared.
    applyStimulus(1'b1, 4'b1111, randOps(), randOps(), 1'b1, -1);
    applyStimulus(1'b1, 4'b1111, randOps(), randOps(), 1'b1, -1);
    checkOutput("reset_valid", 32'(res_valid), 32'(0));
    checkOutput("reset_data",  32'(res_data),  32'(0));

    // Fairness: continuous requests rotate 0..3 twice, one result per cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'b1111, randOps(), randOps(), 1'b1, k % N);
      if (k > 0) checkOutput("fair_valid", 32'(res_valid), 32'(1));
    end

    // Single request from requester 2, then hold it to inspect the result.
    a = randOps(); b = randOps();
    a[2*W +: W] = 8'hF0; b[2*W +: W] = 8'h3C;
    applyStimulus(1'b0, 4'b0100, a, b, 1'b1, 2);
    applyStimulus(1'b0, 4'b0000, randOps(), randOps(), 1'b0, -1);
    checkOutput("single_data", 32'(res_data), 32'hCC);
    checkOutput("single_id",   32'(res_id),   32'd2);

    // Wrap from ptr=3 to 0, then skip ahead to requester 1.
    applyStimulus(1'b0, 4'b1001, randOps(), randOps(), 1'b1, 3);
    applyStimulus(1'b0, 4'b1001, randOps(), randOps(), 1'b1, 0);
    applyStimulus(1'b0, 4'b0010, randOps(), randOps(), 1'b1, 1);

    // Backpressure: held result stays put, then refills with no bubble.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b0011, randOps(), randOps(), 1'b0, -1);
      checkOutput("stall_id", 32'(res_id), 32'd1);
    end
    applyStimulus(1'b0, 4'b0011, randOps(), randOps(), 1'b1, 0);

    // Reset while FULL with ptr=2 drops the result and restarts at requester 0.
    applyStimulus(1'b0, 4'b0010, randOps(), randOps(), 1'b1, 1);
    applyStimulus(1'b1, 4'b0000, randOps(), randOps(), 1'b0, -1);
    applyStimulus(1'b0, 4'b1111, randOps(), randOps(), 1'b1, 0);
    checkOutput("rst_mid_valid", 32'(res_valid), 32'(0));

    // Randomized traffic with occasional stalls and resets.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 49) == 0), N'($urandom), randOps(), randOps(),
                    ($urandom_range(0, 9) < 7), -2);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 Parameter W, default 8, operand and result width in bits.
REQ-002 Parameter N, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N  per-requester request strobe.
REQ-006 req_a  input  N*W  operand A, requester i at bits [i*W +: W].
REQ-007 req_b  input  N*W  operand B, same packing as req_a.
REQ-008 req_ready  output  N  one-hot grant; requester i's transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_data  output  W  A ^ B of the granted request.
REQ-011 res_id  output  clog2(N)  index of the requester that produced res_data.
REQ-012 res_ready  input  1  downstream accepts the result when res_valid and res_ready are both high.

Function
REQ-013 The block SHALL share one W-bit XOR unit among N requesters, with at most one grant per cycle.
REQ-014 The FSM SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-015 The block is able to accept a request when the state is EMPTY, or when it is FULL and res_ready=1 in the same cycle (pass-through, no bubble).
REQ-016 req_ready SHALL be combinational: it is all zeros when the block cannot accept; otherwise it is one-hot on the first requester with req_valid high, searching from the round-robin pointer ptr upward modulo N.
REQ-017 req_ready SHALL be all zeros when no req_valid bit is high.
REQ-018 On a transfer from requester g: res_data <= a_g ^ b_g; res_id <= g; state <= FULL; ptr <= (g+1) mod N; latency is 1 cycle from transfer to res_valid.
REQ-019 In FULL with res_ready=1 and no transfer, the state SHALL go to EMPTY; res_data and res_id SHALL hold their last values.
REQ-020 In FULL with res_ready=0, res_valid, res_data and res_id SHALL be held stable and req_ready SHALL be 0.
REQ-021 ptr SHALL change only on a transfer; an idle cycle or a stalled cycle leaves ptr unchanged.
REQ-022 Wrap-around: a grant to requester N-1 SHALL set ptr to 0.
REQ-023 When all requesters hold req_valid continuously and the output is never stalled, grants SHALL rotate 0,1,...,N-1,0 with one result per cycle.
REQ-024 Result arithmetic SHALL be a pure bitwise XOR with width exactly W, with no carry and no truncation.
REQ-025 Requester inputs sampled without a grant SHALL have no effect on state.

Reset
REQ-026 While rst=1 at a clock edge: state <= EMPTY, res_valid <= 0, res_data <= 0, res_id <= 0, ptr <= 0.
REQ-027 req_ready SHALL be forced to 0 in any cycle where rst=1.
REQ-028 A reset asserted while FULL SHALL discard the held result, and the next grant after reset SHALL start the search from requester 0.

Structure
REQ-029 The shared package SHALL define the state enumeration (EMPTY, FULL) and a helper for the clog2(N) index width.
REQ-030 One sub-module, rr_pick, SHALL implement the combinational round-robin priority search (inputs: valid vector, ptr; outputs: one-hot grant, grant index).
REQ-031 The XOR unit SHALL be instantiated exactly once, with operands selected by a mux on the grant index.

Verification
REQ-032 Reset: assert rst for 2 cycles with all req_valid=1 -> req_ready=0000, res_valid=0, res_data=00, res_id=0.
REQ-033 Single request: req_valid=0100, a2=8'hF0, b2=8'h3C, res_ready=1 -> req_ready=0100 in that cycle; next cycle res_valid=1, res_data=8'hCC, res_id=2.
REQ-034 Fairness: req_valid=1111 held for 8 cycles with res_ready=1 -> grant sequence 0,1,2,3,0,1,2,3 and one result per cycle.
REQ-035 Backpressure: FULL with res_ready=0 for 3 cycles while req_valid=0011 -> req_ready=0000 and res_data, res_id stable; when res_ready goes to 1 -> grant issued in that same cycle, with no bubble.
REQ-036 Wrap and skip: ptr=3, req_valid=1001 -> grant 3, then grant 0; then with req_valid=0010 -> grant 1.
REQ-037 Reset mid-operation: rst pulsed while FULL with ptr=2 -> res_valid=0 the next cycle; a following req_valid=1111 -> grant 0.
